// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan sequencer: FSM state encoding,
// channel geometry and bit-search functions over the 8-bit channel mask.
package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  // Mask with every bit strictly above idx set.
  function automatic logic [NUM_CH-1:0] above_mask(input logic [SEL_W-1:0] idx);
    above_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i > int'(idx)) above_mask[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Combinational channel search: next enabled channel strictly above the
// current index (never wrapping) and the lowest enabled channel overall.
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_cur_idx,
  output logic [SEL_W-1:0]  o_next_idx,
  output logic              o_has_next,
  output logic [SEL_W-1:0]  o_first_idx
);

  logic [NUM_CH-1:0] w_above;

  assign w_above     = i_mask & above_mask(i_cur_idx);
  assign o_has_next  = |w_above;
  assign o_next_idx  = lowest_set(w_above);
  assign o_first_idx = lowest_set(i_mask);

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: drives select/active-low enable of a 3-to-8 decoder,
// stepping ascending through the latched channel mask with a programmable
// dwell per channel and one break-before-make gap cycle between channels.
// Optional macro SCAN_LOOP_EN: repeat the frame (via a gap) until stop
// instead of returning to IDLE after the last channel.
module scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int NUM_CH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic [NUM_CH-1:0]           ch_mask,
  input  logic [DWELL_W-1:0]          dwell,
  output logic [scan_pkg::SEL_W-1:0]  s,
  output logic                        en,
  output logic                        busy,
  output logic                        ch_done,
  output logic                        frame_done
);

  import scan_pkg::*;

  state_t              r_state;
  logic [DWELL_W-1:0]  r_cnt;   // remaining dwell cycles, including the current one
  logic [DWELL_W-1:0]  r_dwl;   // latched dwell, already clamped to >= 1
  logic [NUM_CH-1:0]   r_mask;

  logic [SEL_W-1:0]    w_next_idx;
  logic [SEL_W-1:0]    w_first_idx;
  logic                w_has_next;
  logic [DWELL_W-1:0]  w_in_dwl;
  logic [SEL_W-1:0]    w_in_first;
  logic                w_in_single;
  logic                w_dwl_one;
  logic                w_next_is_last;
  logic                w_first_is_last;

  scan_next_ch u_next (
    .i_mask      (r_mask),
    .i_cur_idx   (s),
    .o_next_idx  (w_next_idx),
    .o_has_next  (w_has_next),
    .o_first_idx (w_first_idx)
  );

  // A dwell of 0 behaves like 1.
  assign w_in_dwl   = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_in_first = lowest_set(ch_mask);
  // Single-cycle dwells pulse done on DWELL entry, so "is this the frame's
  // last channel" has to be known for the channel being entered.
  assign w_in_single     = ~|(ch_mask & above_mask(w_in_first));
  assign w_dwl_one       = (r_dwl == DWELL_W'(1));
  assign w_next_is_last  = ~|(r_mask & above_mask(w_next_idx));
  assign w_first_is_last = ~|(r_mask & above_mask(w_first_idx));

  // Sequencer FSM with dwell counter and registered decoder/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dwl      <= '0;
      r_mask     <= '0;
      s          <= '0;
      en         <= 1'b1;
      busy       <= 1'b0;
      ch_done    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ch_done    <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop && (|ch_mask)) begin
            r_mask     <= ch_mask;
            r_dwl      <= w_in_dwl;
            r_cnt      <= w_in_dwl;
            s          <= w_in_first;
            en         <= 1'b0;
            busy       <= 1'b1;
            r_state    <= DWELL;
            ch_done    <= (w_in_dwl == DWELL_W'(1));
            frame_done <= (w_in_dwl == DWELL_W'(1)) && w_in_single;
          end
        end
        DWELL: begin
          if (stop) begin
            en      <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == DWELL_W'(1)) begin
            en <= 1'b1;
            if (w_has_next) begin
              r_state <= GAP;
            end else begin
`ifdef SCAN_LOOP_EN
              r_state <= GAP;
`else
              busy    <= 1'b0;
              r_state <= IDLE;
`endif
            end
          end else begin
            r_cnt      <= r_cnt - DWELL_W'(1);
            ch_done    <= (r_cnt == DWELL_W'(2));
            frame_done <= (r_cnt == DWELL_W'(2)) && !w_has_next;
          end
        end
        GAP: begin
          if (stop) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            en      <= 1'b0;
            r_cnt   <= r_dwl;
            r_state <= DWELL;
            ch_done <= w_dwl_one;
            // No channel above means a new pass (loop mode only).
            if (w_has_next) begin
              s          <= w_next_idx;
              frame_done <= w_dwl_one && w_next_is_last;
            end else begin
              s          <= w_first_idx;
              frame_done <= w_dwl_one && w_first_is_last;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a queue-based frame model predicts every output
// cycle, a negedge process compares, and directed cases pin literal results.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop;
  logic [7:0] ch_mask, dwell;
  logic [2:0] s;
  logic       en, busy, ch_done, frame_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(8), .NUM_CH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .ch_mask(ch_mask), .dwell(dwell), .s(s), .en(en), .busy(busy),
    .ch_done(ch_done), .frame_done(frame_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each entry is one output cycle: {s, en, busy, ch_done, frame_done}
  logic [6:0] q[$];
  logic [2:0] m_s = 3'd0;
  logic       m_en = 1'b1, m_busy = 1'b0, m_chd = 1'b0, m_frd = 1'b0;
  logic [7:0] lmask, ldw;

  task automatic push_frame(input logic [7:0] m, input logic [7:0] d);
    int dd, hi;
    bit first;
    logic [2:0] prev;
    dd = (d == 0) ? 1 : int'(d);
    hi = 0;
    for (int c = 0; c < 8; c++) if (m[c]) hi = c;
    first = 1;
    prev = 3'd0;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        if (!first) q.push_back({prev, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < dd; k++)
          q.push_back({3'(c), 1'b0, 1'b1, (k == dd - 1), (k == dd - 1) && (c == hi)});
        prev = 3'(c);
        first = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_s = 3'd0; m_en = 1'b1; m_busy = 1'b0; m_chd = 1'b0; m_frd = 1'b0;
    end else if (m_busy && stop) begin
      q.delete();
      m_en = 1'b1; m_busy = 1'b0; m_chd = 1'b0; m_frd = 1'b0;
    end else if (m_busy) begin
      if (q.size() == 0) begin
`ifdef SCAN_LOOP_EN
        q.push_back({m_s, 1'b1, 1'b1, 1'b0, 1'b0});
        push_frame(lmask, ldw);
`else
        m_en = 1'b1; m_busy = 1'b0; m_chd = 1'b0; m_frd = 1'b0;
`endif
      end
      if (q.size() != 0) {m_s, m_en, m_busy, m_chd, m_frd} = q.pop_front();
    end else if (start && !stop && ch_mask != 8'd0) begin
      lmask = ch_mask;
      ldw   = dwell;
      push_frame(lmask, ldw);
      {m_s, m_en, m_busy, m_chd, m_frd} = q.pop_front();
    end
  end

  // ---------------- compare + activity counters ----------------
  int busy_cnt = 0, chd_cnt = 0, frd_cnt = 0;
  logic [2:0] chd_s[8];

  always @(negedge clk) begin
    chk("s", 32'(s), 32'(m_s));
    chk("en", 32'(en), 32'(m_en));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ch_done", 32'(ch_done), 32'(m_chd));
    chk("frame_done", 32'(frame_done), 32'(m_frd));
    if (busy) busy_cnt++;
    if (frame_done) frd_cnt++;
    if (ch_done) begin
      if (chd_cnt < 8) chd_s[chd_cnt] = s;
      chd_cnt++;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    busy_cnt = 0; chd_cnt = 0; frd_cnt = 0;
  endtask

  task automatic launch(input logic [7:0] m, input logic [7:0] d);
    clr();
    ch_mask = m; dwell = d; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ch_mask = 8'd0; dwell = 8'd0;
    repeat (3) cyc();
    chk("rst_s", 32'(s), 0);
    chk("rst_en", 32'(en), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cyc();

    // start with empty mask is ignored
    launch(8'h00, 8'd3);
    repeat (3) cyc();
    chk("mask0_busy_cnt", busy_cnt, 0);

    // start and stop together in IDLE: stop wins
    clr();
    ch_mask = 8'hFF; dwell = 8'd2; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    repeat (3) cyc();
    chk("startstop_busy_cnt", busy_cnt, 0);

`ifdef SCAN_LOOP_EN
    // two channels, dwell 2: 0,0,gap,1,1,gap repeating
    launch(8'h03, 8'd2);
    repeat (23) cyc();
    chk("loop_busy_cnt", busy_cnt, 24);
    chk("loop_chd_cnt", chd_cnt, 8);
    chk("loop_frd_cnt", frd_cnt, 4);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("loop_stop_busy", 32'(busy), 0);
    chk("loop_stop_en", 32'(en), 1);

    // single channel keeps the gap between passes
    launch(8'h04, 8'd1);
    repeat (9) cyc();
    chk("loop1_frd_cnt", frd_cnt, 5);
    chk("loop1_busy_cnt", busy_cnt, 10);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("loop1_stop_busy", 32'(busy), 0);
`else
    // mask A5, dwell 3: channels 0,2,5,7
    launch(8'hA5, 8'd3);
    repeat (19) cyc();
    chk("a5_busy_cnt", busy_cnt, 15);
    chk("a5_chd_cnt", chd_cnt, 4);
    chk("a5_frd_cnt", frd_cnt, 1);
    chk("a5_seq0", 32'(chd_s[0]), 0);
    chk("a5_seq1", 32'(chd_s[1]), 2);
    chk("a5_seq2", 32'(chd_s[2]), 5);
    chk("a5_seq3", 32'(chd_s[3]), 7);

    // dwell 0 on channel 7 only
    launch(8'h80, 8'd0);
    repeat (4) cyc();
    chk("d0_busy_cnt", busy_cnt, 1);
    chk("d0_chd_cnt", chd_cnt, 1);
    chk("d0_frd_cnt", frd_cnt, 1);
    chk("d0_s", 32'(s), 7);

    // stop in the 2nd dwell cycle of channel 2
    launch(8'hFF, 8'd4);
    repeat (11) cyc();
    chk("stop_pre_s", 32'(s), 2);
    chk("stop_pre_en", 32'(en), 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_en", 32'(en), 1);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_s", 32'(s), 2);
    cyc();
    chk("stop_chd_cnt", chd_cnt, 2);

    // start pulsed mid-frame with new mask/dwell: frame unchanged
    launch(8'h11, 8'd2);
    ch_mask = 8'hFF; dwell = 8'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (8) cyc();
    chk("midstart_busy_cnt", busy_cnt, 5);
    chk("midstart_chd_cnt", chd_cnt, 2);

    // maximum dwell
    launch(8'h01, 8'd255);
    repeat (259) cyc();
    chk("dmax_busy_cnt", busy_cnt, 255);
    chk("dmax_chd_cnt", chd_cnt, 1);
`endif

    // asynchronous reset mid-frame
    launch(8'hFF, 8'd3);
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_s", 32'(s), 0);
    chk("arst_en", 32'(en), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_chd", 32'(ch_done), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // randomized frames with stray starts, stops, input churn and resets
    for (int it = 0; it < 60; it++) begin
      ch_mask = 8'($urandom);
      dwell   = 8'($urandom_range(0, 4));
      start   = 1'b1;
      stop    = ($urandom_range(0, 9) == 0);
      cyc();
      start = 1'b0; stop = 1'b0;
      for (int k = 0, n = $urandom_range(1, 40); k < n; k++) begin
        start   = ($urandom_range(0, 3) == 0);
        stop    = ($urandom_range(0, 24) == 0);
        ch_mask = 8'($urandom);
        dwell   = 8'($urandom_range(0, 6));
        if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      start = 1'b0;
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
